// File: rtl/memory_stream_reader_if.sv
// Bundles the control, memory read port and output stream of memory_stream_reader.
// master = reader engine side, slave = host/memory/consumer side.
interface memory_stream_reader_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW:0]      length;
    logic             busy;
    logic             done;
    logic             mem_read_enable;
    logic [AW-1:0]    mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  start, start_addr, length, mem_read_data, out_ready,
        output busy, done, mem_read_enable, mem_read_addr, out_data, out_valid, out_last
    );

    modport slave (
        output start, start_addr, length, mem_read_data, out_ready,
        input  busy, done, mem_read_enable, mem_read_addr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/memory_stream_reader.sv
// Walks a contiguous memory range and streams the words out through a 2-entry buffer.
// Optional MEMORY_STREAM_READER_LAST_EN: out_last flags the final word of each transfer.
module memory_stream_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    memory_stream_reader_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW:0]      remaining_q, remaining_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       occ_q, occ_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] fifo_q [2];
    logic [WIDTH-1:0] fifo_d [2];

    logic             pop;
    logic             issue;
    logic [2:0]       level;
    logic [AW:0]      len_clamped;

    // level is the buffer fill after this cycle's capture and pop; gating issue on it
    // keeps occupancy plus in-flight at or below 2 without a bubble.
    always_comb begin
        pop         = (occ_q != 2'd0) && bus.out_ready;
        level       = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        issue       = (state_q == S_RUN) && (remaining_q != '0) && (level < 3'd2);
        len_clamped = (bus.length > DEPTH_W) ? DEPTH_W : bus.length;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        occ_d       = level[1:0];
        rd_ptr_d    = rd_ptr_q ^ pop;
        wr_ptr_d    = wr_ptr_q ^ inflight_q;
        fifo_d      = fifo_q;

        if (inflight_q) begin
            fifo_d[wr_ptr_q] = bus.mem_read_data;
        end

        if (issue) begin
            addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (bus.start) begin
                    addr_d      = bus.start_addr;
                    remaining_d = len_clamped;
                    state_d     = (len_clamped == '0) ? S_FINISH : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue && (remaining_q == (AW+1)'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (level == 3'd0)) begin
                    state_d = S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fifo_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_q      <= fifo_d;
        end
    end

    assign bus.busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done            = (state_q == S_FINISH);
    assign bus.mem_read_enable = issue;
    assign bus.mem_read_addr   = addr_q;
    assign bus.out_valid       = (occ_q != 2'd0);
    assign bus.out_data        = fifo_q[rd_ptr_q];

`ifdef MEMORY_STREAM_READER_LAST_EN
    logic inflight_last_q, inflight_last_d;
    logic last_q [2];
    logic last_d [2];

    always_comb begin
        inflight_last_d = issue && (remaining_q == (AW+1)'(1));
        last_d          = last_q;
        if (inflight_q) begin
            last_d[wr_ptr_q] = inflight_last_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_last_q <= 1'b0;
            last_q          <= '{default: 1'b0};
        end else begin
            inflight_last_q <= inflight_last_d;
            last_q          <= last_d;
        end
    end

    assign bus.out_last = (occ_q != 2'd0) && last_q[rd_ptr_q];
`else
    assign bus.out_last = 1'b0;
`endif
endmodule

// File: tb/tb_memory_stream_reader.sv
// Scoreboard bench for memory_stream_reader with a registered-read memory model.
module tb_memory_stream_reader;
    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
`ifdef MEMORY_STREAM_READER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    memory_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    memory_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bus.mem_read_enable) bus.mem_read_data <= mem[bus.mem_read_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   clear_seq = 0;
    int   seen_seq  = 0;
    int   hs_count, issue_count, done_count, max_out;
    int   first_hs, last_hs, done_cyc, busy_first, busy_last;
    logic prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    int   ready_mode = 0;
    logic [5:0] ready_pat = 6'b101001;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge clock) begin
        exp_t e;
        if (clear_seq != seen_seq) begin
            seen_seq    = clear_seq;
            hs_count    = 0;
            issue_count = 0;
            done_count  = 0;
            max_out     = 0;
            first_hs    = -1;
            last_hs     = -1;
            done_cyc    = -1;
            busy_first  = -1;
            busy_last   = -1;
        end
        if (bus.done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (issue_count - hs_count > max_out) max_out = issue_count - hs_count;
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && exp_q.size() != 0) begin
                check("out_last", bus.out_last, exp_q[0].last);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                end
                hs_count++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (bus.mem_read_enable) issue_count++;
            if (bus.busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            bus.out_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 6];
        end
    end

    task automatic clear_stats();
        clear_seq++;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic push(input logic [WIDTH-1:0] data, input bit is_final);
        exp_t e;
        e.data = data;
        e.last = is_final && LAST_EN;
        exp_q.push_back(e);
    endtask

    task automatic start_xfer(input int addr, input int len, output int e0);
        @(posedge clock);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = 8'(addr);
        bus.length     = 9'(len);
        @(posedge clock);
        #1;
        e0        = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (done_count > 0) break;
        end
        check("done_seen", done_count > 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_en"}, bus.mem_read_enable, 0);
        check({tag, "_rd_addr"}, bus.mem_read_addr, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int done_before;
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'(16'h1000 + a);
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        reset          = 1'b1;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic transfer: latency, throughput, busy/done timing.
        clear_stats();
        push(16'h1002, 0); push(16'h1003, 0); push(16'h1004, 0); push(16'h1005, 1);
        start_xfer(2, 4, e0);
        wait_done(40);
        check("t1_first_hs", first_hs, e0 + 2);
        check("t1_last_hs", last_hs, e0 + 5);
        check("t1_done_cyc", done_cyc, e0 + 6);
        check("t1_busy_first", busy_first, e0);
        check("t1_busy_last", busy_last, e0 + 5);
        check("t1_hs_count", hs_count, 4);
        check("t1_sb_empty", exp_q.size(), 0);

        // Address wrap.
        clear_stats();
        push(16'h10FE, 0); push(16'h10FF, 0); push(16'h1000, 0); push(16'h1001, 1);
        start_xfer(DEPTH - 2, 4, e0);
        wait_done(40);
        check("t2_done_cyc", done_cyc, e0 + 6);
        check("t2_hs_count", hs_count, 4);
        check("t2_sb_empty", exp_q.size(), 0);

        // Backpressure.
        clear_stats();
        ready_mode = 1;
        for (int i = 0; i < 8; i++) push(16'(16'h1000 + i), i == 7);
        start_xfer(0, 8, e0);
        wait_done(200);
        check("t3_hs_count", hs_count, 8);
        check("t3_issue_count", issue_count, 8);
        check("t3_max_buffered", max_out <= 2, 1);
        check("t3_sb_empty", exp_q.size(), 0);
        ready_mode = 0;

        // Zero length.
        clear_stats();
        start_xfer(5, 0, e0);
        repeat (6) @(negedge clock);
        #1;
        check("t4_done_cyc", done_cyc, e0);
        check("t4_done_count", done_count, 1);
        check("t4_issue_count", issue_count, 0);
        check("t4_hs_count", hs_count, 0);

        // Start while busy is ignored.
        clear_stats();
        push(16'h1004, 0); push(16'h1005, 1);
        start_xfer(4, 2, e0);
        bus.start      = 1'b1;
        bus.start_addr = 8'd0;
        bus.length     = 9'd5;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_done(40);
        repeat (10) @(negedge clock);
        #1;
        check("t5_hs_count", hs_count, 2);
        check("t5_issue_count", issue_count, 2);
        check("t5_done_count", done_count, 1);
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a transfer.
        clear_stats();
        for (int i = 0; i < 6; i++) push(16'(16'h1000 + i), i == 5);
        start_xfer(0, 6, e0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            #1;
            if (hs_count >= 3) break;
        end
        check("t6_reached_3", hs_count >= 3, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        done_before = done_count;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        check("t6_no_done", done_count, done_before);
        clear_stats();
        push(16'h1000, 0); push(16'h1001, 1);
        start_xfer(0, 2, e0);
        wait_done(40);
        check("t6_hs_count", hs_count, 2);
        check("t6_sb_empty", exp_q.size(), 0);

        // Last flag, with stalls.
        clear_stats();
        ready_mode = 1;
        push(16'h1003, 0); push(16'h1004, 0); push(16'h1005, 1);
        start_xfer(3, 3, e0);
        wait_done(100);
        check("t7_hs_count", hs_count, 3);
        check("t7_sb_empty", exp_q.size(), 0);
        ready_mode = 0;

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
